// File: rtl/rst_seq.sv
// Power-on reset sequencer.
// Keeps N_OUT reset domains asserted while the clock source is unlocked, then
// releases them in index order: rst_out[0] after INIT_DELAY cycles, and each
// following bit STAGE_DELAY cycles after the one before it. A synchronous soft
// request re-runs the whole sequence, and hold pauses it. seq_done/busy report
// whether the sequence is complete. All outputs are registered.
module rst_seq #(
  parameter int N_OUT       = 3,
  parameter int DELAY_W     = 8,
  parameter int INIT_DELAY  = 16,
  parameter int STAGE_DELAY = 8,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic             clk,
  input  logic             locked,
  input  logic             soft_rst_req,
  input  logic             hold,
  output logic [N_OUT-1:0] rst_out,
  output logic             seq_done,
  output logic             busy
);

  // stage has to count up to N_OUT, so it needs room for N_OUT+1 values.
  localparam int SW = $clog2(N_OUT + 1);

  localparam logic             ASSERT_LVL   = (ACTIVE_HIGH != 0);
  localparam logic             RELEASE_LVL  = ~ASSERT_LVL;
  localparam logic [N_OUT-1:0] ALL_ASSERTED = {N_OUT{ASSERT_LVL}};

  // Terminal counts. cnt never goes above the larger of these, so it never wraps.
  localparam logic [DELAY_W-1:0] INIT_LAST  = DELAY_W'(INIT_DELAY - 1);
  localparam logic [DELAY_W-1:0] STAGE_LAST = DELAY_W'(STAGE_DELAY - 1);
  localparam logic [SW-1:0]      LAST_STAGE = SW'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_STAGE,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [DELAY_W-1:0] cnt_q;
  logic [SW-1:0]      stage_q;
  logic [N_OUT-1:0]   rst_out_q;
  logic               seq_done_q;
  logic               busy_q;

  // Sequencer FSM. The priority order is lock loss, then soft request, then hold,
  // then counting.
  // NOTE: every register here is sequential state, so each one is assigned with
  // non-blocking <=. That keeps reads of the *_q values consistent within an edge.
  always_ff @(posedge clk or negedge locked) begin
    if (!locked) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      stage_q    <= '0;
      rst_out_q  <= ALL_ASSERTED;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else if (soft_rst_req) begin
      // This edge becomes edge 0 of a fresh sequence.
      state_q    <= S_INIT;
      cnt_q      <= '0;
      stage_q    <= '0;
      rst_out_q  <= ALL_ASSERTED;
      seq_done_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          if (!hold) begin
            if (cnt_q == INIT_LAST) begin
              rst_out_q[0] <= RELEASE_LVL;
              cnt_q        <= '0;
              stage_q      <= SW'(1);
              if (N_OUT == 1) begin
                state_q    <= S_DONE;
                seq_done_q <= 1'b1;
                busy_q     <= 1'b0;
              end else begin
                state_q <= S_STAGE;
              end
            end else begin
              cnt_q <= cnt_q + DELAY_W'(1);
            end
          end
        end

        S_STAGE: begin
          if (!hold) begin
            if (cnt_q == STAGE_LAST) begin
              // Release the bit selected by stage. Bits below it are already
              // released, which keeps the asserted bits contiguous at the top.
              for (int k = 0; k < N_OUT; k++) begin
                if (SW'(k) == stage_q) begin
                  rst_out_q[k] <= RELEASE_LVL;
                end
              end
              cnt_q   <= '0;
              stage_q <= stage_q + SW'(1);
              if (stage_q == LAST_STAGE) begin
                state_q    <= S_DONE;
                seq_done_q <= 1'b1;
                busy_q     <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + DELAY_W'(1);
            end
          end
        end

        S_DONE: begin
          // Stay here until lock is lost or a soft request arrives. Hold has no
          // effect in this state.
        end

        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign rst_out  = rst_out_q;
  assign seq_done = seq_done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed testbench for rst_seq. It runs the default configuration, plus a
// single-output, active-low, INIT_DELAY=1 configuration.
// Edge numbers are counted in e, where edge 1 is the first rising edge after
// the sequence starts. Outputs are sampled 1ns after each rising edge.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       locked_a, soft_a, hold_a;
  logic [2:0] rst_a;
  logic       done_a, busy_a;

  logic       locked_b, soft_b, hold_b;
  logic [0:0] rst_b;
  logic       done_b, busy_b;

  int compared   = 0;
  int mismatched = 0;
  int e          = 0;

  rst_seq dut_a (
    .clk         (clk),
    .locked      (locked_a),
    .soft_rst_req(soft_a),
    .hold        (hold_a),
    .rst_out     (rst_a),
    .seq_done    (done_a),
    .busy        (busy_a)
  );

  rst_seq #(
    .N_OUT      (1),
    .ACTIVE_HIGH(0),
    .INIT_DELAY (1)
  ) dut_b (
    .clk         (clk),
    .locked      (locked_b),
    .soft_rst_req(soft_b),
    .hold        (hold_b),
    .rst_out     (rst_b),
    .seq_done    (done_b),
    .busy        (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  // Check rst_out, seq_done and busy of dut_a together.
  task automatic chk_a(input string tag, input logic [2:0] r, input logic d);
    check({tag, ".rst"}, {29'd0, rst_a}, {29'd0, r});
    check({tag, ".done"}, {31'd0, done_a}, {31'd0, d});
    check({tag, ".busy"}, {31'd0, busy_a}, {31'd0, ~d});
  endtask

  initial begin
    locked_a = 1'b1; soft_a = 1'b0; hold_a = 1'b0;
    locked_b = 1'b1; soft_b = 1'b0; hold_b = 1'b0;
    #2;
    locked_a = 1'b0;
    locked_b = 1'b0;
    #1;
    // Reset values take effect asynchronously.
    chk_a("reset_async", 3'b111, 1'b0);
    check("b_reset_rst", {31'd0, rst_b}, 32'd0);
    check("b_reset_done", {31'd0, done_b}, 32'd0);
    tick(); tick();
    chk_a("reset_clocked", 3'b111, 1'b0);

    // 1) Basic sequence from lock: releases at edges 16 / 24 / 32.
    locked_a = 1'b1;
    locked_b = 1'b1;
    e = 0;
    check("b_pre_edge1", {31'd0, rst_b}, 32'd0);
    tick();
    check("b_edge1_rst", {31'd0, rst_b}, 32'd1);
    check("b_edge1_done", {31'd0, done_b}, 32'd1);
    check("b_edge1_busy", {31'd0, busy_b}, 32'd0);
    chk_a("e1", 3'b111, 1'b0);
    run_to(15); chk_a("e15", 3'b111, 1'b0);
    run_to(16); chk_a("e16", 3'b110, 1'b0);
    run_to(23); chk_a("e23", 3'b110, 1'b0);
    run_to(24); chk_a("e24", 3'b100, 1'b0);
    run_to(31); chk_a("e31", 3'b100, 1'b0);
    run_to(32); chk_a("e32", 3'b000, 1'b1);
    run_to(40); chk_a("e40_done_stays", 3'b000, 1'b1);

    // 2) Lock lost between edges 20 and 21 must reset at once, without a clock,
    //    and the next lock must start the full sequence again.
    locked_a = 1'b0; hold_a = 1'b0;
    e = 0; soft_a = 1'b1; tick(); soft_a = 1'b0;   // restart so e counts from 0
    locked_a = 1'b1; e = 0; tick(); e = 0;
    soft_a = 1'b1; tick(); soft_a = 1'b0; e = 0;
    run_to(20); chk_a("lk_e20", 3'b110, 1'b0);
    locked_a = 1'b0;
    #1;
    chk_a("lk_async", 3'b111, 1'b0);
    tick(); tick();
    locked_a = 1'b1;
    e = 0;
    run_to(15); chk_a("relk_e15", 3'b111, 1'b0);
    run_to(16); chk_a("relk_e16", 3'b110, 1'b0);
    run_to(24); chk_a("relk_e24", 3'b100, 1'b0);
    run_to(32); chk_a("relk_e32", 3'b000, 1'b1);

    // 3) A one-cycle soft request in S_DONE, sampled at edge 50, gives releases
    //    at 66 / 74 / 82.
    run_to(49);
    soft_a = 1'b1;
    tick();
    soft_a = 1'b0;
    chk_a("sr_e50", 3'b111, 1'b0);
    run_to(65); chk_a("sr_e65", 3'b111, 1'b0);
    run_to(66); chk_a("sr_e66", 3'b110, 1'b0);
    run_to(74); chk_a("sr_e74", 3'b100, 1'b0);
    run_to(81); chk_a("sr_e81", 3'b100, 1'b0);
    run_to(82); chk_a("sr_e82", 3'b000, 1'b1);

    // 4) Hold sampled at edges 10..14 gives releases at 21 / 29 / 37.
    soft_a = 1'b1; tick(); soft_a = 1'b0; e = 0;
    run_to(9);
    hold_a = 1'b1;
    run_to(14);
    hold_a = 1'b0;
    chk_a("hd_e14", 3'b111, 1'b0);
    run_to(20); chk_a("hd_e20", 3'b111, 1'b0);
    run_to(21); chk_a("hd_e21", 3'b110, 1'b0);
    run_to(28); chk_a("hd_e28", 3'b110, 1'b0);
    run_to(29); chk_a("hd_e29", 3'b100, 1'b0);
    run_to(36); chk_a("hd_e36", 3'b100, 1'b0);
    run_to(37); chk_a("hd_e37", 3'b000, 1'b1);
    // Hold has no effect once the sequence is done.
    hold_a = 1'b1;
    run_to(45); chk_a("hd_in_done", 3'b000, 1'b1);
    hold_a = 1'b0;

    // 5) Soft request and hold both high at edge 28. Hold stays high through edge
    //    30 and drops before edge 31, so rst_out[0] releases at edge 46.
    e = 27;
    soft_a = 1'b1; hold_a = 1'b1;
    tick();
    soft_a = 1'b0;
    chk_a("sh_e28", 3'b111, 1'b0);
    run_to(30);
    hold_a = 1'b0;
    chk_a("sh_e30", 3'b111, 1'b0);
    run_to(45); chk_a("sh_e45", 3'b111, 1'b0);
    run_to(46); chk_a("sh_e46", 3'b110, 1'b0);
    run_to(54); chk_a("sh_e54", 3'b100, 1'b0);
    run_to(62); chk_a("sh_e62", 3'b000, 1'b1);

    // 6) Keeping the soft request high holds everything in reset.
    soft_a = 1'b1;
    e = 0;
    run_to(20);
    chk_a("sr_level_held", 3'b111, 1'b0);
    soft_a = 1'b0;
    e = 0;
    run_to(16); chk_a("sr_rel_e16", 3'b110, 1'b0);

    // The other DUT should still be done, since it was never disturbed.
    check("b_final_rst", {31'd0, rst_b}, 32'd1);
    check("b_final_done", {31'd0, done_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
